// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared constants and FSM state type for the iterative E-stage divider.
//   DIV_CYCLES : number of restoring radix-2 steps (one per BUSY cycle)
//   CNT_W      : width of the step counter
//   div_state_e: IDLE / BUSY / DONE, encoded from legacy-compatible constants
// -----------------------------------------------------------------------------
package div_unit_pkg;

   localparam int unsigned DIV_CYCLES = 32;
   localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Pipeline-side handshake/bus bundle of the divider.
//   master : pipeline (drives request/control, receives stall and results)
//   slave  : div_unit
// Signals:
//   div_startE, div_signedE, src_aE, src_bE  - request and operands
//   d_cache_stall, flush_exceptionM          - pipeline control
//   alu_stallE, div_readyE, div_hiE, div_loE - stall request and results
// -----------------------------------------------------------------------------
interface div_unit_if;

   logic        div_startE;
   logic        div_signedE;
   logic [31:0] src_aE;
   logic [31:0] src_bE;
   logic        d_cache_stall;
   logic        flush_exceptionM;
   logic        alu_stallE;
   logic        div_readyE;
   logic [31:0] div_hiE;
   logic [31:0] div_loE;

   modport master (
      output div_startE, div_signedE, src_aE, src_bE, d_cache_stall, flush_exceptionM,
      input  alu_stallE, div_readyE, div_hiE, div_loE
   );

   modport slave (
      input  div_startE, div_signedE, src_aE, src_bE, d_cache_stall, flush_exceptionM,
      output alu_stallE, div_readyE, div_hiE, div_loE
   );

endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// 32-step restoring divider for MIPS DIV/DIVU in the E stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - div_unit_if.slave (request, operands, stall/flush, results)
// The pipeline is held (alu_stallE) from the issue cycle through the last
// BUSY step; results are presented in DONE until the instruction leaves E.
// -----------------------------------------------------------------------------
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   div_unit_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [63:0]       rq_q, rq_d;        // {remainder, quotient}
   logic [31:0]       divisor_q, divisor_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;

   logic              start_ok;
   logic [31:0]       a_mag, b_mag;
   logic [32:0]       partial;
   logic [33:0]       trial;
   logic [63:0]       step_rq;
   logic [31:0]       rem_mag, quo_mag;

   assign start_ok = bus.div_startE & ~bus.flush_exceptionM;

   assign a_mag = (bus.div_signedE & bus.src_aE[31]) ? -bus.src_aE : bus.src_aE;
   assign b_mag = (bus.div_signedE & bus.src_bE[31]) ? -bus.src_bE : bus.src_bE;

   // Shifted remainder can reach 33 bits when the divisor exceeds 2^31, so the
   // trial subtraction is one bit wider still to expose the borrow cleanly.
   assign partial = rq_q[63:31];
   assign trial   = {1'b0, partial} - {2'b00, divisor_q};
   assign step_rq = trial[33] ? {partial[31:0], rq_q[30:0], 1'b0}
                              : {trial[31:0],   rq_q[30:0], 1'b1};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rq_d      = rq_q;
      divisor_d = divisor_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;

      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d   = BUSY;
               cnt_d     = '0;
               rq_d      = {32'd0, a_mag};
               divisor_d = b_mag;
               neg_quo_d = bus.div_signedE & (bus.src_aE[31] ^ bus.src_bE[31]);
               neg_rem_d = bus.div_signedE & bus.src_aE[31];
            end
         end
         BUSY: begin
            rq_d  = step_rq;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!bus.d_cache_stall) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Exception flush overrides everything and discards any partial result.
      if (bus.flush_exceptionM) begin
         state_d   = IDLE;
         cnt_d     = '0;
         rq_d      = '0;
         neg_quo_d = 1'b0;
         neg_rem_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rq_q      <= '0;
         divisor_q <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rq_q      <= rq_d;
         divisor_q <= divisor_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   assign rem_mag = rq_q[63:32];
   assign quo_mag = rq_q[31:0];

   assign bus.div_hiE    = neg_rem_q ? -rem_mag : rem_mag;
   assign bus.div_loE    = neg_quo_q ? -quo_mag : quo_mag;
   assign bus.div_readyE = ~rst & (state_q == DONE);
   assign bus.alu_stallE = ~rst & ~bus.flush_exceptionM &
                           (((state_q == IDLE) & bus.div_startE) | (state_q == BUSY));

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: a table of directed divides with
// hand-computed quotient/remainder, plus sequences for reset, flush,
// d_cache_stall hold and back-to-back issue.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic clk;
   logic rst;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      int          hold;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Issues a divide in the current (idle) cycle, measures the stall length,
   // then holds DONE for 'hold' extra cycles with d_cache_stall high while
   // div_startE stays asserted.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input int hold, input string name);
      int n;
      @(negedge clk);
      bus.div_startE       = 1'b1;
      bus.div_signedE      = sgn;
      bus.src_aE           = a;
      bus.src_bE           = b;
      bus.d_cache_stall    = 1'b0;
      bus.flush_exceptionM = 1'b0;
      #1;
      chk({name, "_ready_idle"}, 32'(bus.div_readyE), 32'd0);
      n = 0;
      while (bus.alu_stallE && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk({name, "_stall_len"}, 32'(n), 32'd33);
      for (int i = 0; i <= hold; i++) begin
         bus.d_cache_stall = (i < hold);
         if (i == hold) bus.div_startE = 1'b0;
         #1;
         chk($sformatf("%s_ready_c%0d", name, i), 32'(bus.div_readyE), 32'd1);
         chk($sformatf("%s_stall_c%0d", name, i), 32'(bus.alu_stallE), 32'd0);
         chk($sformatf("%s_lo_c%0d", name, i), bus.div_loE, lo);
         chk($sformatf("%s_hi_c%0d", name, i), bus.div_hiE, hi);
         if (i < hold) @(negedge clk);
      end
   endtask

   task automatic watch_no_ready(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         if (bus.div_readyE || bus.alu_stallE) seen++;
      end
      chk(name, 32'(seen), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   0};
      vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
      vecs[3]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   0};
      vecs[4]  = '{1'b1, 32'd45,         32'd4,          32'd11,         32'd1,          0};
      vecs[5]  = '{1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          0};
      vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          0};
      vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   0};
      vecs[8]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   0};
      vecs[9]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          0};
      vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          0};
      vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   5};

      // Reset: outputs quiet even with a start request pending.
      rst                  = 1'b1;
      bus.div_startE       = 1'b1;
      bus.div_signedE      = 1'b0;
      bus.src_aE           = 32'd100;
      bus.src_bE           = 32'd7;
      bus.d_cache_stall    = 1'b0;
      bus.flush_exceptionM = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 32'(bus.alu_stallE), 32'd0);
      chk("rst_ready", 32'(bus.div_readyE), 32'd0);
      chk("rst_lo", bus.div_loE, 32'd0);
      chk("rst_hi", bus.div_hiE, 32'd0);
      bus.div_startE = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Table vectors, issued back to back (covers 45/4 then 9/3 as well).
      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
                 vecs[i].hold, $sformatf("v%0d", i));
      end

      // Flush and start in the same idle cycle: flush wins.
      @(negedge clk);
      bus.div_startE       = 1'b1;
      bus.div_signedE      = 1'b0;
      bus.src_aE           = 32'd50;
      bus.src_bE           = 32'd5;
      bus.flush_exceptionM = 1'b1;
      #1;
      chk("flush_start_stall", 32'(bus.alu_stallE), 32'd0);
      @(negedge clk);
      bus.div_startE       = 1'b0;
      bus.flush_exceptionM = 1'b0;
      #1;
      chk("flush_start_not_busy", 32'(bus.alu_stallE), 32'd0);
      watch_no_ready("flush_start_quiet", 5);

      // Flush in BUSY at counter = 10.
      @(negedge clk);
      bus.div_startE = 1'b1;
      bus.src_aE     = 32'd1000;
      bus.src_bE     = 32'd3;
      repeat (11) @(negedge clk);
      #1;
      chk("busy10_stall", 32'(bus.alu_stallE), 32'd1);
      bus.flush_exceptionM = 1'b1;
      #1;
      chk("busy10_flush_stall", 32'(bus.alu_stallE), 32'd0);
      @(negedge clk);
      bus.flush_exceptionM = 1'b0;
      bus.div_startE       = 1'b0;
      #1;
      chk("busy10_idle_stall", 32'(bus.alu_stallE), 32'd0);
      chk("busy10_idle_ready", 32'(bus.div_readyE), 32'd0);
      watch_no_ready("busy10_no_ready", 40);

      run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0, "after_flush");

      // Reset asserted mid-BUSY aborts the operation.
      @(negedge clk);
      bus.div_startE = 1'b1;
      bus.src_aE     = 32'd77;
      bus.src_bE     = 32'd8;
      repeat (6) @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_busy_stall", 32'(bus.alu_stallE), 32'd0);
      chk("rst_busy_ready", 32'(bus.div_readyE), 32'd0);
      bus.div_startE = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      watch_no_ready("rst_busy_no_ready", 40);

      run_div(1'b1, 32'hFFFFFFB3, 32'd8, 32'hFFFFFFF7, 32'hFFFFFFFB, 0, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have no parameters; iteration count DIV_CYCLES = 32 is a package constant.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 div_startE  input  1  E-stage instruction is DIV/DIVU and is not being flushed.
REQ-005 div_signedE  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 src_aE  input  32  dividend.
REQ-007 src_bE  input  32  divisor.
REQ-008 d_cache_stall  input  1  memory-side stall; pipeline cannot advance out of E.
REQ-009 flush_exceptionM  input  1  exception flush; abort any operation.
REQ-010 alu_stallE  output  1  stall request to the hazard unit while the division is incomplete.
REQ-011 div_readyE  output  1  hi/lo results valid.
REQ-012 div_hiE  output  32  remainder.
REQ-013 div_loE  output  32  quotient.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE->BUSY when div_startE=1 and flush_exceptionM=0; operand magnitudes, sign flags and opcode latched on that edge; counter cleared to 0.
REQ-016 alu_stallE SHALL equal (IDLE & div_startE & ~flush_exceptionM) | BUSY, combinationally, so the stall is raised in the issue cycle.
REQ-017 BUSY: one restoring radix-2 step per cycle on a 64-bit {remainder,quotient} register; counter increments 0..31; after step 31 -> DONE.
REQ-018 Total stall length SHALL be exactly 33 cycles from issue cycle to first cycle with alu_stallE=0.
REQ-019 DONE: alu_stallE=0, div_readyE=1, div_hiE/div_loE hold final values.
REQ-020 DONE->IDLE when d_cache_stall=0 (instruction leaves E); DONE SHALL persist while d_cache_stall=1 and SHALL NOT restart on the still-present div_startE.
REQ-021 Signed: divide magnitudes; quotient negated iff operand signs differ; remainder takes the dividend's sign (MIPS semantics); -2^31 / -1 yields lo=0x80000000, hi=0.
REQ-022 Divide by zero: no exception; lo=0xFFFFFFFF, hi=dividend magnitude before sign fix (sign fix still applied); latency unchanged.
REQ-023 flush_exceptionM=1 in any state SHALL force IDLE on the next edge, deassert alu_stallE combinationally in that cycle, and discard partial results.
REQ-024 flush_exceptionM and div_startE in the same IDLE cycle: flush wins, no start.
REQ-025 div_readyE SHALL be 0 outside DONE; div_hiE/div_loE are don't-care outside DONE but SHALL be deterministic (register contents).
REQ-026 Back-to-back divides: a new div_startE is accepted only from IDLE, i.e. at the earliest the cycle after DONE exits.

Reset
REQ-027 rst=1 SHALL asynchronously set state=IDLE, counter=0, datapath registers=0; alu_stallE=0 and div_readyE=0 while in reset (alu_stallE is gated by ~rst).
REQ-028 Reset asserted mid-BUSY SHALL abort without producing div_readyE.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE/BUSY/DONE) and DIV_CYCLES.
REQ-030 Single module, no sub-modules; sign fix-up is inline combinational logic on the final register.

Verification
REQ-031 DIVU 100/7 -> alu_stallE high 33 cycles, then div_readyE=1, lo=14, hi=2.
REQ-032 DIV 0xFFFFFFF9 / 2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678, stall 33 cycles, no hang.
REQ-034 Flush at BUSY counter=10 -> alu_stallE=0 that cycle, IDLE next cycle, div_readyE never asserted.
REQ-035 d_cache_stall=1 for 5 cycles on entering DONE -> DONE held 6 cycles, results stable, no restart; then IDLE.
REQ-036 Two consecutive DIVs (45/4 then 9/3) -> results 11 r1 then 3 r0, second stall begins the cycle after first DONE exits.
